// File: rtl/uart_reg_cmd.sv
`timescale 1ns/1ps
// Byte-stream register command decoder sitting behind uart_rx: decodes read/write
// commands, holds an 8-bit register file and returns read data toward the UART TX.
module uart_reg_cmd #(
  parameter int unsigned NUM_REGS       = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter logic [7:0]  RESET_VAL      = 8'h00
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  output logic                  tx_valid,
  output logic [7:0]            tx_data,
  input  logic                  tx_ready,
  output logic [NUM_REGS*8-1:0] reg_out,
  output logic [NUM_REGS-1:0]   reg_wr_stb,
  output logic                  cmd_err,
  input  logic                  clr_err
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_VAL,
    S_RD_RESP
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [6:0]           r_addr;
  logic [CW-1:0]        r_cnt;
  logic [7:0]           r_regs [NUM_REGS];
  logic                 r_tx_valid;
  logic [7:0]           r_tx_data;
  logic [NUM_REGS-1:0]  r_wr_stb;
  logic                 r_err;

  logic                 w_cmd_in_range;
  logic                 w_val_in_range;
  logic                 w_timeout;
  logic                 w_is_cmd;
  logic [7:0]           w_rd_val;
  logic                 w_latch_addr;
  logic                 w_load_tx;
  logic                 w_tx_done;
  logic                 w_wr_en;
  logic                 w_set_err;
  logic                 w_cnt_inc;

  assign w_is_cmd       = rx_valid && (rx_data != 8'h00);
  assign w_cmd_in_range = (rx_data[6:0] != '0) && (rx_data[6:0] <= 7'(NUM_REGS));
  assign w_val_in_range = (r_addr != '0) && (r_addr <= 7'(NUM_REGS));
  assign w_timeout      = (r_cnt == CW'(TIMEOUT_CYCLES - 1));

  // Read data is taken from the register array at the command cycle; out-of-range gives FF.
  always_comb begin
    w_rd_val = 8'hFF;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (rx_data[6:0] == 7'(i + 1)) w_rd_val = r_regs[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     if (w_is_cmd) w_next = rx_data[7] ? S_WAIT_VAL : S_RD_RESP;
      S_WAIT_VAL: if (rx_valid || w_timeout) w_next = S_IDLE;
      S_RD_RESP:  if (r_tx_valid && tx_ready) w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_latch_addr = 1'b0;
    w_load_tx    = 1'b0;
    w_tx_done    = 1'b0;
    w_wr_en      = 1'b0;
    w_set_err    = 1'b0;
    w_cnt_inc    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_is_cmd) begin
          if (rx_data[7]) begin
            w_latch_addr = 1'b1;
          end else begin
            w_load_tx = 1'b1;
            w_set_err = !w_cmd_in_range;
          end
        end
      end
      S_WAIT_VAL: begin
        // A value byte arriving on the timeout cycle still wins.
        if (rx_valid) begin
          w_wr_en   = w_val_in_range;
          w_set_err = !w_val_in_range;
        end else if (w_timeout) begin
          w_set_err = 1'b1;
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
      S_RD_RESP: begin
        w_set_err = rx_valid;
        w_tx_done = r_tx_valid && tx_ready;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr     <= '0;
      r_cnt      <= '0;
      r_tx_valid <= 1'b0;
      r_tx_data  <= '0;
      r_wr_stb   <= '0;
      r_err      <= 1'b0;
      for (int unsigned i = 0; i < NUM_REGS; i++) r_regs[i] <= RESET_VAL;
    end else begin
      r_wr_stb <= '0;
      if (w_latch_addr) begin
        r_addr <= rx_data[6:0];
        r_cnt  <= '0;
      end else if (w_cnt_inc) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_load_tx) begin
        r_tx_valid <= 1'b1;
        r_tx_data  <= w_rd_val;
      end else if (w_tx_done) begin
        r_tx_valid <= 1'b0;
      end
      if (w_wr_en) begin
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
          if (r_addr == 7'(i + 1)) begin
            r_regs[i]   <= rx_data;
            r_wr_stb[i] <= 1'b1;
          end
        end
      end
      if (w_set_err)    r_err <= 1'b1;
      else if (clr_err) r_err <= 1'b0;
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_out
    assign reg_out[g*8 +: 8] = r_regs[g];
  end

  assign tx_valid   = r_tx_valid;
  assign tx_data    = r_tx_data;
  assign reg_wr_stb = r_wr_stb;
  assign cmd_err    = r_err;

endmodule

// File: tb/tb_uart_reg_cmd.sv
`timescale 1ns/1ps
// Self-checking bench for uart_reg_cmd: directed scenarios plus randomized command
// traffic compared against a transaction-level register-file model.
module tb_uart_reg_cmd;

  localparam int unsigned NR = 4;
  localparam int unsigned TO = 16;
  localparam logic [7:0]  RV = 8'hA5;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic [31:0] reg_out;
  logic [3:0]  reg_wr_stb;
  logic        cmd_err;
  logic        clr_err;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] m_regs [NR];
  logic       m_err;

  always #5 clk = ~clk;

  uart_reg_cmd #(
    .NUM_REGS      (NR),
    .TIMEOUT_CYCLES(TO),
    .RESET_VAL     (RV)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .tx_ready  (tx_ready),
    .reg_out   (reg_out),
    .reg_wr_stb(reg_wr_stb),
    .cmd_err   (cmd_err),
    .clr_err   (clr_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    tick();
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  task automatic model_reset();
    for (int i = 0; i < NR; i++) m_regs[i] = RV;
    m_err = 1'b0;
  endtask

  function automatic logic [31:0] exp_regs();
    logic [31:0] r;
    for (int i = 0; i < NR; i++) r[i*8 +: 8] = m_regs[i];
    return r;
  endfunction

  task automatic model_write(input int a, input logic [7:0] v, output logic [3:0] stb);
    stb = '0;
    if (a >= 1 && a <= NR) begin
      m_regs[a-1] = v;
      stb[a-1]    = 1'b1;
    end else begin
      m_err = 1'b1;
    end
  endtask

  task automatic model_read(input int a, output logic [7:0] v);
    if (a >= 1 && a <= NR) begin
      v = m_regs[a-1];
    end else begin
      v     = 8'hFF;
      m_err = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; rx_valid = 1'b0; rx_data = '0; tx_ready = 1'b0; clr_err = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    model_reset();
    n_cmp++; if (reg_out !== exp_regs()) begin n_bad++; $display("FAIL rst_regs got=%h exp=%h", reg_out, exp_regs()); end
    n_cmp++; if (tx_valid !== 1'b0) begin n_bad++; $display("FAIL rst_txv got=%b exp=0", tx_valid); end
    n_cmp++; if (tx_data !== 8'h00) begin n_bad++; $display("FAIL rst_txd got=%h exp=00", tx_data); end
    n_cmp++; if (reg_wr_stb !== 4'b0) begin n_bad++; $display("FAIL rst_stb got=%b exp=0000", reg_wr_stb); end
    n_cmp++; if (cmd_err !== 1'b0) begin n_bad++; $display("FAIL rst_err got=%b exp=0", cmd_err); end
  endtask

  task automatic test_write();
    logic [3:0] stb;
    send(8'h81);
    n_cmp++; if (reg_wr_stb !== 4'b0) begin n_bad++; $display("FAIL wr_early_stb got=%b exp=0000", reg_wr_stb); end
    send(8'h5A);
    model_write(1, 8'h5A, stb);
    n_cmp++; if (reg_out !== exp_regs()) begin n_bad++; $display("FAIL wr_regs got=%h exp=%h", reg_out, exp_regs()); end
    n_cmp++; if (reg_wr_stb !== 4'b0001) begin n_bad++; $display("FAIL wr_stb got=%b exp=0001", reg_wr_stb); end
    n_cmp++; if (cmd_err !== 1'b0) begin n_bad++; $display("FAIL wr_err got=%b exp=0", cmd_err); end
    tick();
    n_cmp++; if (reg_wr_stb !== 4'b0) begin n_bad++; $display("FAIL wr_stb_off got=%b exp=0000", reg_wr_stb); end
  endtask

  task automatic test_read();
    logic [3:0] stb;
    send(8'h83);
    send(8'hC3);
    model_write(3, 8'hC3, stb);
    tick();
    tx_ready = 1'b1;
    send(8'h03);
    n_cmp++; if (tx_valid !== 1'b1) begin n_bad++; $display("FAIL rd_txv got=%b exp=1", tx_valid); end
    n_cmp++; if (tx_data !== 8'hC3) begin n_bad++; $display("FAIL rd_txd got=%h exp=c3", tx_data); end
    tick();
    n_cmp++; if (tx_valid !== 1'b0) begin n_bad++; $display("FAIL rd_txv_off got=%b exp=0", tx_valid); end
    tx_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [7:0] exp;
    tx_ready = 1'b0;
    send(8'h02);
    exp = m_regs[1];
    n_cmp++; if (tx_valid !== 1'b1 || tx_data !== exp) begin n_bad++; $display("FAIL bp_first got=%b/%h exp=1/%h", tx_valid, tx_data, exp); end
    for (int i = 0; i < 50; i++) begin
      if (i == 20) begin send(8'h84); m_err = 1'b1; end
      else if (i == 21) send(8'h11);
      else tick();
      n_cmp++; if (tx_valid !== 1'b1 || tx_data !== exp) begin n_bad++; $display("FAIL bp_hold[%0d] got=%b/%h exp=1/%h", i, tx_valid, tx_data, exp); end
    end
    n_cmp++; if (cmd_err !== 1'b1) begin n_bad++; $display("FAIL bp_err got=%b exp=1", cmd_err); end
    n_cmp++; if (reg_out !== exp_regs()) begin n_bad++; $display("FAIL bp_regs got=%h exp=%h", reg_out, exp_regs()); end
    tx_ready = 1'b1;
    tick();
    n_cmp++; if (tx_valid !== 1'b0) begin n_bad++; $display("FAIL bp_done got=%b exp=0", tx_valid); end
    tick();
    n_cmp++; if (tx_valid !== 1'b0) begin n_bad++; $display("FAIL bp_once got=%b exp=0", tx_valid); end
    send(8'h01);
    n_cmp++; if (tx_valid !== 1'b1 || tx_data !== m_regs[0]) begin n_bad++; $display("FAIL bp_idle_rd got=%b/%h exp=1/%h", tx_valid, tx_data, m_regs[0]); end
    tick();
    tx_ready = 1'b0;
    clr_err = 1'b1; tick(); clr_err = 1'b0; m_err = 1'b0;
    n_cmp++; if (cmd_err !== 1'b0) begin n_bad++; $display("FAIL bp_clr got=%b exp=0", cmd_err); end
  endtask

  task automatic test_timeout();
    logic [3:0] stb;
    send(8'h82);
    repeat (TO - 1) tick();
    n_cmp++; if (cmd_err !== 1'b0) begin n_bad++; $display("FAIL to_early got=%b exp=0", cmd_err); end
    tick();
    m_err = 1'b1;
    n_cmp++; if (cmd_err !== 1'b1) begin n_bad++; $display("FAIL to_err got=%b exp=1", cmd_err); end
    tx_ready = 1'b0;
    send(8'h02);
    n_cmp++; if (tx_valid !== 1'b1 || tx_data !== RV) begin n_bad++; $display("FAIL to_rd got=%b/%h exp=1/%h", tx_valid, tx_data, RV); end
    n_cmp++; if (reg_out !== exp_regs()) begin n_bad++; $display("FAIL to_regs got=%h exp=%h", reg_out, exp_regs()); end
    tx_ready = 1'b1; tick(); tx_ready = 1'b0;
    clr_err = 1'b1; tick(); clr_err = 1'b0; m_err = 1'b0;
    send(8'h82);
    repeat (TO - 1) tick();
    send(8'h6E);
    model_write(2, 8'h6E, stb);
    n_cmp++; if (reg_out !== exp_regs()) begin n_bad++; $display("FAIL to_edge_regs got=%h exp=%h", reg_out, exp_regs()); end
    n_cmp++; if (reg_wr_stb !== stb) begin n_bad++; $display("FAIL to_edge_stb got=%b exp=%b", reg_wr_stb, stb); end
    n_cmp++; if (cmd_err !== 1'b0) begin n_bad++; $display("FAIL to_edge_err got=%b exp=0", cmd_err); end
    tick();
  endtask

  task automatic test_bad_addr();
    send(8'h00);
    n_cmp++; if (tx_valid !== 1'b0 || cmd_err !== 1'b0) begin n_bad++; $display("FAIL nop got=%b/%b exp=0/0", tx_valid, cmd_err); end
    tick();
    n_cmp++; if (tx_valid !== 1'b0 || reg_out !== exp_regs()) begin n_bad++; $display("FAIL nop_after got=%b/%h exp=0/%h", tx_valid, reg_out, exp_regs()); end
    send(8'h85);
    send(8'h11);
    m_err = 1'b1;
    n_cmp++; if (cmd_err !== 1'b1) begin n_bad++; $display("FAIL bad_wr_err got=%b exp=1", cmd_err); end
    n_cmp++; if (reg_out !== exp_regs() || reg_wr_stb !== 4'b0) begin n_bad++; $display("FAIL bad_wr got=%h/%b exp=%h/0000", reg_out, reg_wr_stb, exp_regs()); end
    tx_ready = 1'b0;
    send(8'h05);
    n_cmp++; if (tx_valid !== 1'b1 || tx_data !== 8'hFF) begin n_bad++; $display("FAIL bad_rd got=%b/%h exp=1/ff", tx_valid, tx_data); end
    tx_ready = 1'b1; tick(); tx_ready = 1'b0;
    clr_err = 1'b1; tick(); clr_err = 1'b0; m_err = 1'b0;
    n_cmp++; if (cmd_err !== 1'b0) begin n_bad++; $display("FAIL clr got=%b exp=0", cmd_err); end
    send(8'h80);
    rx_valid = 1'b1; rx_data = 8'h11; clr_err = 1'b1;
    tick();
    rx_valid = 1'b0; clr_err = 1'b0;
    m_err = 1'b1;
    n_cmp++; if (cmd_err !== 1'b1) begin n_bad++; $display("FAIL set_prio got=%b exp=1", cmd_err); end
    n_cmp++; if (reg_out !== exp_regs()) begin n_bad++; $display("FAIL addr0_regs got=%h exp=%h", reg_out, exp_regs()); end
    clr_err = 1'b1; tick(); clr_err = 1'b0; m_err = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [3:0] stb;
    tx_ready = 1'b1;
    send(8'h81);
    send(8'h77);
    model_write(1, 8'h77, stb);
    send(8'h01);
    n_cmp++; if (tx_valid !== 1'b1 || tx_data !== 8'h77) begin n_bad++; $display("FAIL b2b_rd got=%b/%h exp=1/77", tx_valid, tx_data); end
    tick();
    n_cmp++; if (tx_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_done got=%b exp=0", tx_valid); end
    tx_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [3:0] stb;
    send(8'h81);
    reset = 1'b1; tick(); reset = 1'b0;
    model_reset();
    n_cmp++; if (reg_out !== exp_regs() || reg_wr_stb !== 4'b0) begin n_bad++; $display("FAIL rm_regs got=%h/%b exp=%h/0000", reg_out, reg_wr_stb, exp_regs()); end
    send(8'h81);
    n_cmp++; if (reg_out !== exp_regs() || reg_wr_stb !== 4'b0) begin n_bad++; $display("FAIL rm_cmd got=%h/%b exp=%h/0000", reg_out, reg_wr_stb, exp_regs()); end
    send(8'h33);
    model_write(1, 8'h33, stb);
    n_cmp++; if (reg_out !== exp_regs() || reg_wr_stb !== stb) begin n_bad++; $display("FAIL rm_wr got=%h/%b exp=%h/%b", reg_out, reg_wr_stb, exp_regs(), stb); end
    tx_ready = 1'b0;
    send(8'h01);
    reset = 1'b1; tick(); reset = 1'b0;
    model_reset();
    n_cmp++; if (tx_valid !== 1'b0 || tx_data !== 8'h00) begin n_bad++; $display("FAIL rm_tx got=%b/%h exp=0/00", tx_valid, tx_data); end
    n_cmp++; if (reg_out !== exp_regs()) begin n_bad++; $display("FAIL rm_regs2 got=%h exp=%h", reg_out, exp_regs()); end
  endtask

  task automatic test_random();
    logic [3:0] stb;
    logic [7:0] v;
    int a, op, k;
    for (int n = 0; n < 80; n++) begin
      op = int'($urandom_range(0, 9));
      if (op <= 3) begin
        a = int'($urandom_range(0, 6));
        v = 8'($urandom);
        send({1'b1, 7'(a)});
        repeat ($urandom_range(0, 3)) tick();
        send(v);
        model_write(a, v, stb);
        n_cmp++; if (reg_out !== exp_regs() || reg_wr_stb !== stb || cmd_err !== m_err) begin n_bad++; $display("FAIL rnd_wr[%0d] a=%0d got=%h/%b/%b exp=%h/%b/%b", n, a, reg_out, reg_wr_stb, cmd_err, exp_regs(), stb, m_err); end
        tick();
        n_cmp++; if (reg_wr_stb !== 4'b0) begin n_bad++; $display("FAIL rnd_stb_off[%0d] got=%b exp=0000", n, reg_wr_stb); end
      end else if (op <= 7) begin
        a = int'($urandom_range(1, 6));
        k = int'($urandom_range(0, 4));
        tx_ready = 1'b0;
        send({1'b0, 7'(a)});
        model_read(a, v);
        n_cmp++; if (tx_valid !== 1'b1 || tx_data !== v || cmd_err !== m_err) begin n_bad++; $display("FAIL rnd_rd[%0d] a=%0d got=%b/%h/%b exp=1/%h/%b", n, a, tx_valid, tx_data, cmd_err, v, m_err); end
        for (int j = 0; j < k; j++) begin
          tick();
          n_cmp++; if (tx_valid !== 1'b1 || tx_data !== v) begin n_bad++; $display("FAIL rnd_hold[%0d] got=%b/%h exp=1/%h", n, tx_valid, tx_data, v); end
        end
        tx_ready = 1'b1;
        tick();
        n_cmp++; if (tx_valid !== 1'b0) begin n_bad++; $display("FAIL rnd_rd_done[%0d] got=%b exp=0", n, tx_valid); end
        tx_ready = 1'b0;
      end else if (op == 8) begin
        send(8'h00);
        n_cmp++; if (tx_valid !== 1'b0 || reg_out !== exp_regs() || cmd_err !== m_err) begin n_bad++; $display("FAIL rnd_nop[%0d] got=%b/%h/%b exp=0/%h/%b", n, tx_valid, reg_out, cmd_err, exp_regs(), m_err); end
      end else begin
        clr_err = 1'b1; tick(); clr_err = 1'b0; m_err = 1'b0;
        n_cmp++; if (cmd_err !== 1'b0) begin n_bad++; $display("FAIL rnd_clr[%0d] got=%b exp=0", n, cmd_err); end
      end
      repeat ($urandom_range(0, 2)) tick();
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_backpressure();
    test_timeout();
    test_bad_addr();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
